apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 100 ++++++++++
 tb/tb_apb_master_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB initiator: turns a valid/ready command into one APB transfer at a time and
// returns read data or a watchdog-timeout status as a single-cycle response pulse.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic [31:0] pwdata,
    output logic        pwrite,
    input  logic        pready,
    input  logic [31:0] prdata
);

    localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wait_cnt;
    logic          done_ok, done_to;

    assign cmd_ready = (state == IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_nxt = state;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE:   if (cmd_valid) state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                // A high pready on the expiry cycle still counts as a normal completion.
                done_ok = pready;
                done_to = !pready && WDOG_EN && (wait_cnt == CNT_LAST);
                if (done_ok || done_to) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state       <= state_nxt;
            psel        <= (state_nxt != IDLE);
            penable     <= (state_nxt == ACCESS);
            rsp_valid   <= done_ok || done_to;
            rsp_timeout <= done_to;

            // Bus address/data are only loaded on accept, so they hold quietly in IDLE.
            if (state == IDLE && cmd_valid) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
            end

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !pready && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (done_ok || done_to) begin
                rsp_rdata <= (done_ok && !pwrite) ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction-timeline reference model,
// directed test-plan scenarios, randomized traffic and an asynchronous mid-transfer reset.
module tb_apb_master_bridge;

    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwdata(pwdata), .pwrite(pwrite),
        .pready(pready), .prdata(prdata)
    );

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;   // prdata the responder returns on its ready cycle
        int          waits;   // pready-low ACCESS cycles before ready
        int          gap;     // idle cycles after previous accept before presenting
    } stim_t;

    stim_t q[$];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    // Current transaction as a timeline: SETUP at t_acc, ACCESS t_acc+1..t_acc+len,
    // response pulse at t_acc+len+1.
    bit          act = 0;
    int          t_acc = 0, len = 0, twait = 0;
    bit          tw = 0;
    logic [31:0] trd = '0;
    logic [31:0] e_paddr = '0, e_pwdata = '0;
    bit          e_pwrite = 0;
    bit          prev_ready = 0;
    int          gap_cnt = 0;
    int          n_acc = 0;
    int          acc_c[512], rsp_c[512];
    logic [31:0] rsp_d[512];
    bit          rsp_t[512];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic stim_t mk(bit w, logic [31:0] a, logic [31:0] wd, logic [31:0] rd,
                                 int waits, int gap);
        stim_t s;
        s.write = w; s.addr = a; s.wdata = wd; s.rdata = rd; s.waits = waits; s.gap = gap;
        return s;
    endfunction

    task automatic model_edge();
        cyc++;
        if (!preset && cmd_valid && prev_ready && q.size() > 0) begin
            act      = 1;
            t_acc    = cyc;
            tw       = cmd_write;
            twait    = q[0].waits;
            trd      = q[0].rdata;
            len      = (twait >= TO) ? TO : twait + 1;
            e_paddr  = cmd_addr;
            e_pwrite = cmd_write;
            e_pwdata = cmd_wdata;
            if (n_acc < 512) acc_c[n_acc] = cyc;
            n_acc++;
            gap_cnt = 0;
            void'(q.pop_front());
        end
    endtask

    task automatic model_reset();
        act = 0;
        e_paddr = '0; e_pwdata = '0; e_pwrite = 0;
        gap_cnt = 0;
    endtask

    task automatic sample();
        bit in_txn, exp_rv;
        in_txn = act && cyc <= t_acc + len;
        exp_rv = act && cyc == t_acc + len + 1;
        check("cmd_ready", cmd_ready, !in_txn);
        check("psel", psel, in_txn);
        check("penable", penable, in_txn && cyc > t_acc);
        check("paddr", paddr, e_paddr);
        check("pwrite", pwrite, e_pwrite);
        check("pwdata", pwdata, e_pwdata);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_timeout", rsp_timeout, twait >= TO);
            check("rsp_rdata", rsp_rdata, (twait >= TO || tw) ? 32'h0 : trd);
        end
        if (rsp_valid === 1'b1 && n_acc > 0 && n_acc <= 512) begin
            rsp_c[n_acc-1] = cyc;
            rsp_d[n_acc-1] = rsp_rdata;
            rsp_t[n_acc-1] = rsp_timeout;
        end
        prev_ready = !in_txn;
    endtask

    task automatic drive();
        bit present, in_acc;
        present = !preset && q.size() > 0 && gap_cnt >= q[0].gap;
        gap_cnt++;
        cmd_valid = present;
        if (present) begin
            cmd_write = q[0].write;
            cmd_addr  = q[0].addr;
            cmd_wdata = q[0].wdata;
        end else begin
            cmd_write = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
        in_acc = act && cyc >= t_acc + 1 && cyc <= t_acc + len;
        if (in_acc) begin
            pready = (cyc == t_acc + 1 + twait);
            prdata = pready ? trd : $urandom;
        end else begin
            pready = 1'($urandom);
            prdata = $urandom;
        end
    endtask

    task automatic run_cycle();
        @(posedge pclk);
        model_edge();
        @(negedge pclk);
        sample();
        drive();
    endtask

    function automatic bit busy();
        return q.size() > 0 || (act && cyc <= t_acc + len + 1);
    endfunction

    task automatic run_until_idle(int budget);
        int n = 0;
        while (busy() && n < budget) begin
            run_cycle();
            n++;
        end
        n_cmp++;
        if (busy()) begin
            n_bad++;
            $display("FAIL cycle_budget: still busy after %0d cycles, required idle", n);
            q.delete();
        end
    endtask

    initial begin
        int n, rel_edge;
        for (int i = 0; i < 512; i++) begin
            acc_c[i] = -1; rsp_c[i] = -1; rsp_d[i] = '0; rsp_t[i] = 0;
        end

        repeat (3) run_cycle();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        q.push_back(mk(1, 32'h0000_0010, 32'hA5A5_5A5A, 32'h0, 0, 0));
        q.push_back(mk(0, 32'h0000_0020, 32'h1111_1111, 32'hDEAD_BEEF, 3, 2));
        q.push_back(mk(0, 32'h0000_0030, 32'h2222_2222, 32'h0BAD_0BAD, 100, 1));
        q.push_back(mk(0, 32'h0000_0034, 32'h3333_3333, 32'h1234_5678, TO - 1, 1));
        q.push_back(mk(1, 32'h0000_0004, 32'h0000_0001, 32'h0, 0, 3));
        q.push_back(mk(1, 32'h0000_0008, 32'h0000_0002, 32'h0, 0, 0));
        q.push_back(mk(1, 32'h0000_000C, 32'h0000_0003, 32'h0, 0, 0));
        q.push_back(mk(0, 32'h0000_0040, 32'h4444_4444, 32'h5555_5555, 8, 2));
        q.push_back(mk(0, 32'h0000_0044, 32'h6666_6666, 32'hCAFE_F00D, 0, 0));

        preset = 1'b0;
        drive();

        // Run into the ACCESS phase of the eighth transfer, then reset asynchronously.
        n = 0;
        while (!(act && n_acc == 8 && cyc >= t_acc + 3) && n < 500) begin
            run_cycle();
            n++;
        end
        check("reach_reset_point", n < 500, 1);
        #1 preset = 1'b1;
        #1;
        check("async_rst_psel", psel, 0);
        check("async_rst_penable", penable, 0);
        check("async_rst_rsp_valid", rsp_valid, 0);
        check("async_rst_paddr", paddr, 0);
        model_reset();
        repeat (2) run_cycle();
        preset = 1'b0;
        drive();
        rel_edge = cyc + 1;
        run_until_idle(2000);

        check("zw_write_latency", rsp_c[0] - acc_c[0], 2);
        check("zw_write_timeout", rsp_t[0], 0);
        check("rd3_latency", rsp_c[1] - acc_c[1], 5);
        check("rd3_rdata", rsp_d[1], 32'hDEAD_BEEF);
        check("tmo_latency", rsp_c[2] - acc_c[2], TO + 1);
        check("tmo_flag", rsp_t[2], 1);
        check("tmo_rdata", rsp_d[2], 0);
        check("edge_ready_latency", rsp_c[3] - acc_c[3], TO + 1);
        check("edge_ready_flag", rsp_t[3], 0);
        check("edge_ready_rdata", rsp_d[3], 32'h1234_5678);
        check("b2b_gap1", acc_c[5] - acc_c[4], 3);
        check("b2b_gap2", acc_c[6] - acc_c[5], 3);
        check("b2b_total", rsp_c[6] + 1 - acc_c[4], 9);
        check("rst_dropped_no_rsp", rsp_c[7], -1);
        check("post_rst_accept_edge", acc_c[8], rel_edge);
        check("post_rst_latency", rsp_c[8] - acc_c[8], 2);
        check("post_rst_rdata", rsp_d[8], 32'hCAFE_F00D);

        for (int i = 0; i < 150; i++) begin
            int r, w;
            r = int'($urandom_range(0, 9));
            if (r < 6)       w = r % 4;
            else if (r == 6) w = TO - 1;
            else if (r == 7) w = TO;
            else if (r == 8) w = TO + 3;
            else             w = 0;
            q.push_back(mk(1'($urandom), $urandom, $urandom, $urandom, w,
                           int'($urandom_range(0, 2))));
        end
        run_until_idle(20000);
        check("random_all_accepted", n_acc, 159);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
